// File: rtl/iir_notch_biquad_if.sv
// Sample and coefficient bundle for the notch biquad.
// The master drives samples and coefficients; the slave returns the filtered stream.
interface iir_notch_biquad_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 20
);
    logic                          valid_in;
    logic signed [DATA_WIDTH-1:0]  x_in;
    logic                          coeff_load;
    logic signed [COEFF_WIDTH-1:0] b0;
    logic signed [COEFF_WIDTH-1:0] b1;
    logic signed [COEFF_WIDTH-1:0] b2;
    logic signed [COEFF_WIDTH-1:0] a1;
    logic signed [COEFF_WIDTH-1:0] a2;
    logic                          bypass;
    logic signed [DATA_WIDTH-1:0]  y_out;
    logic                          valid_out;
    logic                          ovf;

    modport master (
        output valid_in, x_in, coeff_load,
        output b0, b1, b2, a1, a2, bypass,
        input  y_out, valid_out, ovf
    );

    modport slave (
        input  valid_in, x_in, coeff_load,
        input  b0, b1, b2, a1, a2, bypass,
        output y_out, valid_out, ovf
    );
endinterface

// File: rtl/iir_notch_biquad.sv
// Direct Form I biquad notch, one-cycle latency, s16.15 data, s20.18 coefficients.
// Coefficients land in a shadow set and swap in on the next sample boundary.
module iir_notch_biquad #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 20,
    parameter int COEFF_FRAC  = 18,
    parameter int ACC_WIDTH   = 40
) (
    input logic               clk,
    input logic               rst_n,
    iir_notch_biquad_if.slave bus
);
    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam logic signed [COEFF_WIDTH-1:0] C_ONE =
        COEFF_WIDTH'(2 ** COEFF_FRAC);
    localparam logic signed [ACC_WIDTH-1:0] RND =
        ACC_WIDTH'(2 ** (COEFF_FRAC - 1));
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
        ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;

    // Index order: b0, b1, b2, a1, a2
    logic signed [COEFF_WIDTH-1:0] act_q  [5];
    logic signed [COEFF_WIDTH-1:0] sh_q   [5];
    logic signed [COEFF_WIDTH-1:0] port_c [5];
    logic signed [COEFF_WIDTH-1:0] use_c  [5];
    logic signed [PW-1:0]          prod   [5];

    logic                          pend_q, pend_d;
    logic                          vld_q;
    logic                          ovf_q, ovf_d;
    logic signed [DATA_WIDTH-1:0]  y_q, y_d;
    logic signed [DATA_WIDTH-1:0]  x1_q, x2_q, y1_q, y2_q;
    logic signed [ACC_WIDTH-1:0]   acc, rnd;
    logic signed [DATA_WIDTH-1:0]  sat;
    logic                          clamp;

    always_comb begin
        port_c[0] = bus.b0;
        port_c[1] = bus.b1;
        port_c[2] = bus.b2;
        port_c[3] = bus.a1;
        port_c[4] = bus.a2;
        // A pending shadow set is exactly what this sample must use
        for (int i = 0; i < 5; i++)
            use_c[i] = pend_q ? sh_q[i] : act_q[i];
    end

    always_comb begin
        prod[0] = PW'(use_c[0]) * PW'(bus.x_in);
        prod[1] = PW'(use_c[1]) * PW'(x1_q);
        prod[2] = PW'(use_c[2]) * PW'(x2_q);
        prod[3] = PW'(use_c[3]) * PW'(y1_q);
        prod[4] = PW'(use_c[4]) * PW'(y2_q);
        acc = ACC_WIDTH'(prod[0]) + ACC_WIDTH'(prod[1])
            + ACC_WIDTH'(prod[2]) - ACC_WIDTH'(prod[3])
            - ACC_WIDTH'(prod[4]);
        rnd = (acc + RND) >>> COEFF_FRAC;
        clamp = 1'b1;
        if (rnd > Y_MAX)
            sat = Y_MAX[DATA_WIDTH-1:0];
        else if (rnd < Y_MIN)
            sat = Y_MIN[DATA_WIDTH-1:0];
        else begin
            clamp = 1'b0;
            sat   = rnd[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        y_d    = y_q;
        ovf_d  = ovf_q;
        pend_d = bus.coeff_load | (pend_q & ~bus.valid_in);
        if (bus.valid_in) begin
            y_d   = bus.bypass ? bus.x_in : sat;
            ovf_d = ovf_q | (clamp & ~bus.bypass);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                act_q[i] <= '0;
                sh_q[i]  <= '0;
            end
            act_q[0] <= C_ONE;
            sh_q[0]  <= C_ONE;
            pend_q   <= 1'b0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            y_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            y1_q     <= '0;
            y2_q     <= '0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= bus.valid_in;
            ovf_q  <= ovf_d;
            y_q    <= y_d;
            for (int i = 0; i < 5; i++) begin
                if (bus.valid_in && pend_q)
                    act_q[i] <= sh_q[i];
                if (bus.coeff_load)
                    sh_q[i] <= port_c[i];
            end
            if (bus.valid_in) begin
                x2_q <= x1_q;
                x1_q <= bus.x_in;
                y2_q <= y1_q;
                y1_q <= y_d;
            end
        end
    end

    assign bus.y_out     = y_q;
    assign bus.valid_out = vld_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_iir_notch_biquad.sv
// Directed bench for the notch biquad with a reference model
// feeding an expected-output queue.
module tb_iir_notch_biquad;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iir_notch_biquad_if #(.DATA_WIDTH(16), .COEFF_WIDTH(20)) bus ();

    iir_notch_biquad dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int expq[$];

    longint m_act[5];
    longint m_sh[5];
    bit     m_pend;
    bit     m_ovf;
    longint mx1, mx2, my1, my2;

    task automatic chk(string tag, logic signed [63:0] obs,
                       logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_act  = '{262144, 0, 0, 0, 0};
        m_sh   = m_act;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
        expq.delete();
    endtask

    task automatic setc(int b0, int b1, int b2, int a1, int a2);
        bus.b0 = 20'(b0);
        bus.b1 = 20'(b1);
        bus.b2 = 20'(b2);
        bus.a1 = 20'(a1);
        bus.a2 = 20'(a2);
    endtask

    task automatic step(bit v, int x, bit byp = 1'b0, bit ld = 1'b0);
        longint u[5];
        longint acc;
        longint y;
        bus.valid_in   = v;
        bus.x_in       = 16'(x);
        bus.bypass     = byp;
        bus.coeff_load = ld;
        for (int i = 0; i < 5; i++)
            u[i] = m_pend ? m_sh[i] : m_act[i];
        if (v) begin
            if (byp) begin
                y = x;
            end else begin
                acc = u[0] * x + u[1] * mx1 + u[2] * mx2
                    - u[3] * my1 - u[4] * my2;
                y = (acc + 131072) >>> 18;
                if (y > 32767) begin
                    y = 32767;
                    m_ovf = 1'b1;
                end else if (y < -32768) begin
                    y = -32768;
                    m_ovf = 1'b1;
                end
            end
            mx2 = mx1; mx1 = x;
            my2 = my1; my1 = y;
            expq.push_back(int'(y));
            if (m_pend) begin
                m_act  = m_sh;
                m_pend = 1'b0;
            end
        end
        if (ld) begin
            m_sh[0] = longint'(bus.b0);
            m_sh[1] = longint'(bus.b1);
            m_sh[2] = longint'(bus.b2);
            m_sh[3] = longint'(bus.a1);
            m_sh[4] = longint'(bus.a2);
            m_pend  = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid_out", bus.valid_out, v);
        if (bus.valid_out === 1'b1) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $error("FAIL y_out unexpected sample observed=%0d", bus.y_out);
            end else begin
                chk("y_out", bus.y_out, expq.pop_front());
            end
        end
        chk("ovf", bus.ovf, m_ovf);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.valid_in = 1'b0;
        bus.x_in = '0;
        bus.coeff_load = 1'b0;
        bus.bypass = 1'b0;
        setc(0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_y_out", bus.y_out, 0);
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;

        // Default coefficients: impulse passes unchanged
        step(1, 16384);
        repeat (3) step(1, 0);
        step(0, 0);
        step(1, 0);

        // Single pole at 0.5: decays to a one-LSB limit cycle
        setc(262144, 0, 0, -131072, 0);
        step(0, 0, 0, 1);
        step(1, 16384);
        repeat (18) step(1, 0);

        // Notch at fs/4, then DC gain of two
        setc(262144, 0, 262144, 0, 0);
        step(0, 0, 0, 1);
        repeat (3) begin
            step(1, 16384);
            step(1, 0);
            step(1, -16384);
            step(1, 0);
        end
        repeat (4) step(1, 8192);

        // Saturation at both rails, sticky flag
        setc(524287, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 32767);
        step(1, -32768);
        repeat (2) step(1, 0);

        // Load coinciding with a sample uses the previous set
        setc(262144, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0);
        setc(131072, 0, 0, 0, 0);
        step(1, 16384, 0, 1);
        step(1, 16384);
        step(1, 1234, 1);
        step(1, -5000, 1);
        step(1, 100);
        setc(262144, 0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 7, 1);
        step(1, 200);

        // Mixed gaps and back-to-back samples through a general biquad
        setc(200000, -100000, 50000, -60000, 30000);
        step(0, 0, 0, 1);
        for (int i = 0; i < 24; i++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 20000)) - 10000);

        // Mid-stream reset discards state and a pending load
        step(1, 16384);
        setc(131072, 0, 0, -131072, 0);
        step(0, 0, 0, 1);
        rst_n = 1'b0;
        #2;
        chk("amid_y_out", bus.y_out, 0);
        chk("amid_valid_out", bus.valid_out, 0);
        chk("amid_ovf", bus.ovf, 0);
        m_reset();
        #2;
        rst_n = 1'b1;
        step(1, 16384);
        repeat (3) step(1, 0);

        if (expq.size() != 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL queue_leftover observed=%0d expected=0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/iir_notch_biquad.md
Name: iir_notch_biquad

Overview:
- Second-order IIR (Direct Form I biquad) that consumes the fractional decimator's s16.15 output stream and removes a narrowband interferer.
- Runs on the 18 MHz system clock; a sample arrives on a valid strobe, at up to one every 3 clocks for 6 MHz output.
- Fully parallel datapath with a 1-cycle latency, so the recursion closes before the next sample.
- Coefficients are runtime-loadable with a glitch-free sample-boundary swap; bypass mode and a sticky overflow flag are included.

Parameters:
- DATA_WIDTH, 16, sample width in s16.15 format.
- COEFF_WIDTH, 20, coefficient width in s20.18 format; range [-2, 2).
- COEFF_FRAC, 18, number of coefficient fractional bits.
- ACC_WIDTH, 40, internal accumulator width.

Ports:
- clk  in  1  system clock, 18 MHz.
- rst_n  in  1  asynchronous active-low reset.
- valid_in  in  1  x_in is a new sample this cycle.
- x_in  in  DATA_WIDTH  input sample, s16.15.
- coeff_load  in  1  capture b0/b1/b2/a1/a2 into the shadow set.
- b0, b1, b2  in  COEFF_WIDTH each  feed-forward coefficients, s20.18.
- a1, a2  in  COEFF_WIDTH each  feedback coefficients, s20.18; applied with a minus sign.
- bypass  in  1  pass x_in straight through.
- y_out  out  DATA_WIDTH  filtered sample, s16.15.
- valid_out  out  1  y_out updated this cycle.
- ovf  out  1  sticky saturation flag.

Behaviour:
Reset (rst_n low, asynchronous):
- y_out=0, valid_out=0, ovf=0.
- History registers x1, x2, y1, y2 = 0.
- Active coefficients: b0=262144 (1.0), all others 0. Shadow set equals active. pending=0.

Coefficient handling:
- coeff_load=1 copies the ports into the shadow set and sets pending.
- On a cycle with valid_in=1 and pending=1, that sample is computed with the shadow set. Shadow is copied to active and pending is cleared.
- If coeff_load and valid_in are high in the same cycle, that sample uses the prior set (old shadow if pending was already set, otherwise active). The new values apply from the next sample.

Sample processing (valid_in=1, bypass=0):
- acc = b0*x_in + b1*x1 + b2*x2 - a1*y1 - a2*y2. Products are full precision with 33 fractional bits; the sum uses sign-extended ACC_WIDTH.
- Rounding: add 2^(COEFF_FRAC-1), then arithmetic shift right by COEFF_FRAC (round half up).
- Saturation: clamp to [-32768, 32767]. Any clamp sets ovf=1; ovf holds until reset.
- Registered on the same edge: y_out = sat result, valid_out=1, x2<=x1, x1<=x_in, y2<=y1, y1<=saturated result.
- Latency: y_out and valid_out are valid the cycle after valid_in.

bypass=1 with valid_in=1:
- y_out=x_in and valid_out=1 next cycle.
- History shifts with x1<=x_in and y1<=x_in, so there is no transient on exit.
- ovf is unaffected. A pending coefficient swap is still performed.

Other rules:
- valid_in=0: valid_out=0 next cycle; y_out and history hold.
- Back-to-back valid_in every clock is supported; throughput is 1 sample/clk.
- The rounding limit cycle (y stuck at ±1 LSB) is accepted behaviour and is not corrected.
- Reset mid-stream clears all state immediately and discards any pending coefficients.

Test Plan:
1. Reset then impulse x_in=16384 followed by zeros, default coefficients -> y_out=16384 one cycle after valid_in, then 0; valid_out mirrors valid_in delayed by 1.
2. Load a1=-131072 (-0.5) with b0=1.0, then impulse 16384 -> y = 16384, 8192, 4096, 2048, …, 2, 1, 1, 1 (rounding limit cycle at 1).
3. Notch at fs/4: b0=262144, b1=0, b2=262144, a1=0, a2=0; input 16384, 0, -16384, 0 repeating -> after 2 samples y_out=0 steady state. Input constant 8192 -> y_out=16384.
4. b0=524287 (~2.0), x_in=32767 -> y_out=32767 and ovf=1. x_in=-32768 -> y_out=-32768. ovf stays 1 after the input returns to 0.
5. Assert coeff_load in the same cycle as valid_in with a new b0=131072 -> that sample uses the old b0=1.0; the next sample is halved. bypass=1 -> y_out==x_in with 1-cycle latency.
6. Pulse rst_n low mid-stream after a nonzero response -> outputs, history and ovf are 0 asynchronously. Coefficients revert to b0=1.0, so the next impulse returns unfiltered.
